// File: rtl/jt6295_adpcm.sv
// Four-channel MSM6295-style ADPCM player: CPU command decode, ROM sequencer, per-channel decode and mixer.
// Optional macro JT6295_ATT_EN enables per-channel attenuation; without it every channel plays at full scale.
module jt6295_adpcm (
  input  logic               clk,
  input  logic               rst,
  input  logic               cen,
  input  logic               ss,
  input  logic               wrn,
  input  logic [7:0]         din,
  output logic [7:0]         dout,
  output logic [17:0]        rom_addr,
  input  logic [7:0]         rom_data,
  input  logic               rom_ok,
  output logic               sample,
  output logic signed [13:0] sound
);
  typedef enum logic [1:0] {S_IDLE, S_TBLWAIT, S_DATAWAIT, S_DEC} state_t;

  // Indices above 48 never occur; the padding only keeps the lookup fully defined.
  localparam logic [10:0] STEP_TBL [0:63] = '{
    11'd16,   11'd17,   11'd19,   11'd21,   11'd23,   11'd25,   11'd28,   11'd31,
    11'd34,   11'd37,   11'd41,   11'd45,   11'd50,   11'd55,   11'd60,   11'd66,
    11'd73,   11'd80,   11'd88,   11'd97,   11'd107,  11'd118,  11'd130,  11'd143,
    11'd157,  11'd173,  11'd190,  11'd209,  11'd230,  11'd253,  11'd279,  11'd307,
    11'd337,  11'd371,  11'd408,  11'd449,  11'd494,  11'd544,  11'd598,  11'd658,
    11'd724,  11'd796,  11'd876,  11'd963,  11'd1060, 11'd1166, 11'd1282, 11'd1411,
    11'd1552, 11'd1552, 11'd1552, 11'd1552, 11'd1552, 11'd1552, 11'd1552, 11'd1552,
    11'd1552, 11'd1552, 11'd1552, 11'd1552, 11'd1552, 11'd1552, 11'd1552, 11'd1552};

  state_t             r_state, w_nextState;
  logic               r_wrnLast, r_pending, r_fresh;
  logic [6:0]         r_phrase, r_tblPhrase;
  logic [3:0]         r_tblMask;
  logic [2:0]         r_tblCnt;
  logic [17:0]        r_tblStart;
  logic [9:0]         r_tblEndHi;
  logic [7:0]         r_cnt;
  logic [3:0]         r_busy, r_need, r_low;
  logic [17:0]        r_addr [4];
  logic [17:0]        r_end  [4];
  logic [7:0]         r_byte [4];
  logic signed [11:0] r_sig  [4];
  logic [5:0]         r_idx  [4];
  logic [1:0]         r_cur, w_sel;
`ifdef JT6295_ATT_EN
  logic [3:0]         r_tblAtt;
  logic [3:0]         r_att  [4];
`endif

  logic               w_wrFall, w_romAck, w_wrap, w_tblGo, w_tblBusy, w_anyNeed;
  logic [3:0]         w_needMask, w_nib;
  logic [10:0]        w_step;
  logic [12:0]        w_diff;
  logic signed [13:0] w_sum, w_mix;
  logic signed [11:0] w_newSig;
  logic signed [7:0]  w_idxDelta, w_idxSum;
  logic [5:0]         w_newIdx;
  logic [12:0]        w_out  [4];

  assign dout       = {4'b0000, r_busy};
  assign w_wrFall   = r_wrnLast & ~wrn;
  assign w_romAck   = rom_ok & ~r_fresh;
  assign w_wrap     = cen && (r_cnt == 8'd0);
  assign w_tblGo    = (r_tblMask != 4'd0) || (r_tblCnt != 3'd0);
  assign w_tblBusy  = w_tblGo || (r_state == S_TBLWAIT);
  assign w_needMask = r_need & r_busy;
  assign w_anyNeed  = |w_needMask;

  always_comb begin
    w_sel = 2'd0;
    for (int c = 3; c >= 0; c--)
      if (w_needMask[c]) w_sel = 2'(c);
  end

  // Shared decoder for the channel currently owned by the sequencer.
  always_comb begin
    w_nib  = r_low[r_cur] ? r_byte[r_cur][3:0] : r_byte[r_cur][7:4];
    w_step = STEP_TBL[r_idx[r_cur]];
    w_diff = {5'd0, w_step[10:3]}
           + (w_nib[2] ? {2'd0, w_step} : 13'd0)
           + (w_nib[1] ? {3'd0, w_step[10:1]} : 13'd0)
           + (w_nib[0] ? {4'd0, w_step[10:2]} : 13'd0);
    w_sum  = w_nib[3] ? $signed({{2{r_sig[r_cur][11]}}, r_sig[r_cur]}) - $signed({1'b0, w_diff})
                      : $signed({{2{r_sig[r_cur][11]}}, r_sig[r_cur]}) + $signed({1'b0, w_diff});
    w_newSig = w_sum[11:0];
    if (w_sum > 14'sd2047)       w_newSig = 12'sd2047;
    else if (w_sum < -14'sd2048) w_newSig = -12'sd2048;
    w_idxDelta = -8'sd1;
    if (w_nib[2]) w_idxDelta = $signed({5'd0, w_nib[1:0], 1'b0}) + 8'sd2;
    w_idxSum = $signed({2'b00, r_idx[r_cur]}) + w_idxDelta;
    w_newIdx = w_idxSum[5:0];
    if (w_idxSum < 8'sd0)       w_newIdx = 6'd0;
    else if (w_idxSum > 8'sd48) w_newIdx = 6'd48;
  end

  for (genvar c = 0; c < 4; c++) begin : g_out
`ifdef JT6295_ATT_EN
    logic [5:0]         w_mult;
    logic signed [17:0] w_prod;
    always_comb begin
      case (r_att[c])
        4'd0: w_mult = 6'd32;  4'd1: w_mult = 6'd22;  4'd2: w_mult = 6'd16;
        4'd3: w_mult = 6'd11;  4'd4: w_mult = 6'd8;   4'd5: w_mult = 6'd6;
        4'd6: w_mult = 6'd4;   4'd7: w_mult = 6'd3;   4'd8: w_mult = 6'd2;
        default: w_mult = 6'd0;
      endcase
    end
    assign w_prod   = r_sig[c] * $signed({1'b0, w_mult});
    assign w_out[c] = r_busy[c] ? 13'(w_prod >>> 5) : 13'd0;
`else
    assign w_out[c] = r_busy[c] ? {r_sig[c][11], r_sig[c]} : 13'd0;
`endif
  end

`ifndef JT6295_ATT_EN
  logic w_unused;
  assign w_unused = &{1'b0, din[2:0]};
`endif

  always_comb begin
    w_mix = '0;
    for (int c = 0; c < 4; c++) w_mix = w_mix + $signed({w_out[c][12], w_out[c]});
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_nextState;

  // Table reads win over channel data; a pending low nibble needs no ROM access.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:     if (cen) begin
                    if (w_tblGo)        w_nextState = S_TBLWAIT;
                    else if (w_anyNeed) w_nextState = r_low[w_sel] ? S_DEC : S_DATAWAIT;
                  end
      S_TBLWAIT:  if (w_romAck) w_nextState = S_IDLE;
      S_DATAWAIT: if (w_romAck) w_nextState = S_DEC;
      S_DEC:      if (cen) w_nextState = S_IDLE;
      default:    w_nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sample <= 1'b0;  sound <= '0;  rom_addr <= '0;
      r_wrnLast <= 1'b1;  r_pending <= 1'b0;  r_fresh <= 1'b0;
      r_phrase <= '0;  r_tblPhrase <= '0;  r_tblMask <= '0;  r_tblCnt <= '0;
      r_tblStart <= '0;  r_tblEndHi <= '0;  r_cnt <= '0;
      r_busy <= '0;  r_need <= '0;  r_low <= '0;  r_cur <= '0;
      for (int c = 0; c < 4; c++) begin
        r_addr[c] <= '0;  r_end[c] <= '0;  r_byte[c] <= '0;  r_sig[c] <= '0;  r_idx[c] <= '0;
`ifdef JT6295_ATT_EN
        r_att[c] <= '0;
`endif
      end
`ifdef JT6295_ATT_EN
      r_tblAtt <= '0;
`endif
    end else begin
      sample    <= 1'b0;
      r_wrnLast <= wrn;
      r_fresh   <= 1'b0;
      if (cen) r_cnt <= (r_cnt == 8'd0) ? (ss ? 8'd131 : 8'd164) : r_cnt - 8'd1;
      if (w_wrap) begin
        sample <= 1'b1;
        sound  <= w_mix;
      end
      case (r_state)
        S_IDLE: if (cen) begin
          if (w_tblGo) begin
            rom_addr <= {8'd0, r_tblPhrase, r_tblCnt};
            r_fresh  <= 1'b1;
          end else if (w_anyNeed) begin
            r_cur <= w_sel;
            if (!r_low[w_sel]) begin
              rom_addr <= r_addr[w_sel];
              r_fresh  <= 1'b1;
            end
          end
        end
        S_TBLWAIT: if (w_romAck) begin
          r_tblCnt <= r_tblCnt + 3'd1;
          case (r_tblCnt)
            3'd0: r_tblStart[17:16] <= rom_data[1:0];
            3'd1: r_tblStart[15:8]  <= rom_data;
            3'd2: r_tblStart[7:0]   <= rom_data;
            3'd3: r_tblEndHi[9:8]   <= rom_data[1:0];
            3'd4: r_tblEndHi[7:0]   <= rom_data;
            default: begin
              r_tblCnt  <= 3'd0;
              r_tblMask <= '0;
              for (int c = 0; c < 4; c++) if (r_tblMask[c]) begin
                r_busy[c] <= 1'b1;  r_need[c] <= 1'b1;  r_low[c] <= 1'b0;
                r_addr[c] <= r_tblStart;  r_end[c] <= {r_tblEndHi, rom_data};
                r_sig[c]  <= '0;  r_idx[c] <= '0;
`ifdef JT6295_ATT_EN
                r_att[c]  <= r_tblAtt;
`endif
              end
            end
          endcase
        end
        S_DATAWAIT: if (w_romAck) r_byte[r_cur] <= rom_data;
        S_DEC: if (cen && r_busy[r_cur]) begin
          r_sig[r_cur]  <= w_newSig;
          r_idx[r_cur]  <= w_newIdx;
          r_need[r_cur] <= 1'b0;
          r_low[r_cur]  <= ~r_low[r_cur];
          if (r_low[r_cur]) begin
            if (r_addr[r_cur] == r_end[r_cur]) r_busy[r_cur] <= 1'b0;
            else                               r_addr[r_cur] <= r_addr[r_cur] + 18'd1;
          end
        end
        default: ;
      endcase
      for (int c = 0; c < 4; c++) if (w_wrap && r_busy[c]) r_need[c] <= 1'b1;
      // Commands come last so a stop overrides anything scheduled for that channel this cycle.
      if (w_wrFall) begin
        if (r_pending) begin
          r_pending <= 1'b0;
          if (r_phrase != 7'd0 && !w_tblBusy) begin
            r_tblMask   <= din[7:4] & ~r_busy;
            r_tblPhrase <= r_phrase;
`ifdef JT6295_ATT_EN
            r_tblAtt    <= din[3:0];
`endif
          end
        end else if (din[7]) begin
          r_phrase  <= din[6:0];
          r_pending <= 1'b1;
        end else begin
          for (int c = 0; c < 4; c++) if (din[3+c]) begin
            r_busy[c] <= 1'b0;  r_need[c] <= 1'b0;  r_tblMask[c] <= 1'b0;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_jt6295_adpcm.sv
// Directed bench for jt6295_adpcm: ROM model with a short fixed latency, hand-computed ADPCM results.
module tb_jt6295_adpcm;
  logic               clk = 1'b0, rst = 1'b0, cen = 1'b0, ss = 1'b1, wrn = 1'b1;
  logic [7:0]         din = 8'h00;
  logic [7:0]         dout;
  logic [17:0]        rom_addr;
  logic [7:0]         rom_data = 8'h00;
  logic               rom_ok = 1'b0;
  logic               sample;
  logic signed [13:0] sound;

  logic [7:0]  mem [0:4095];
  logic [1:0]  cenCnt = 2'd0;
  logic [17:0] lastAddr = 18'd0;
  int          romCnt = 0;
  int          cyc = 0, lastSampleCyc = 0, t0 = 0;
  int          errors = 0, checks = 0;
  logic        hit3 = 1'b0, hit0 = 1'b0;
  int          longExp [7] = '{30, 93, 229, 522, 1153, 2047, 2047};
  int          attExp;

  jt6295_adpcm dut (
    .clk(clk), .rst(rst), .cen(cen), .ss(ss), .wrn(wrn), .din(din), .dout(dout),
    .rom_addr(rom_addr), .rom_data(rom_data), .rom_ok(rom_ok), .sample(sample), .sound(sound));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rom_addr >= 18'd24 && rom_addr < 18'd32) hit3 = 1'b1;
    if (rom_addr < 18'd8) hit0 = 1'b1;
  end

  always @(negedge clk) begin
    cenCnt = cenCnt + 2'd1;
    cen = (cenCnt == 2'd0);
  end

  // ROM answers two cycles after the address settles.
  always @(negedge clk) begin
    if (rom_addr != lastAddr) begin
      lastAddr = rom_addr;
      romCnt = 0;
    end else if (romCnt < 8) romCnt = romCnt + 1;
    rom_ok   = (romCnt >= 2);
    rom_data = (rom_addr < 18'd4096) ? mem[rom_addr[11:0]] : 8'h00;
  end

  task automatic checkOutput(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] v);
    @(negedge clk);
    din = v;
    wrn = 1'b0;
    repeat (2) @(negedge clk);
    wrn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic waitSample();
    int n = 0;
    @(negedge clk);
    while (!sample && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("sampleSeen", sample, 1);
    lastSampleCyc = cyc;
  endtask

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    mem[8]  = 8'h00; mem[9]  = 8'h04; mem[10] = 8'h00; mem[11] = 8'h00; mem[12] = 8'h04; mem[13] = 8'h01;
    mem[16] = 8'h00; mem[17] = 8'h05; mem[18] = 8'h00; mem[19] = 8'h00; mem[20] = 8'h05; mem[21] = 8'hFF;
    mem[24] = 8'h00; mem[25] = 8'h06; mem[26] = 8'h00; mem[27] = 8'h00; mem[28] = 8'h06; mem[29] = 8'h10;
    mem[12'h400] = 8'h70;
    mem[12'h401] = 8'h00;
    for (int i = 12'h500; i < 12'h600; i++) mem[i] = 8'h77;
    for (int i = 12'h600; i < 12'h611; i++) mem[i] = 8'h11;

    rst = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput("rstDout", dout, 0);
    checkOutput("rstSound", sound, 0);
    checkOutput("rstSample", sample, 0);
    checkOutput("rstRomAddr", rom_addr, 0);
    rst = 1'b1;

    waitSample();
    t0 = lastSampleCyc;
    checkOutput("idleSound", sound, 0);
    checkOutput("idleDout", dout, 0);
    waitSample();
    checkOutput("period132", lastSampleCyc - t0, 528);

    applyStimulus(8'h81);
    applyStimulus(8'h10);
    waitSample();
    checkOutput("p1Busy", dout, 1);
    checkOutput("p1Nib1", sound, 30);
    waitSample();
    checkOutput("p1Nib2", sound, 34);
    waitSample();
    checkOutput("p1Nib3", sound, 37);
    waitSample();
    checkOutput("p1EndSound", sound, 0);
    checkOutput("p1EndDout", dout, 0);

    mem[12'h400] = 8'hF0;
    applyStimulus(8'h81);
    applyStimulus(8'h10);
    waitSample();
    checkOutput("negNib1", sound, -30);
    waitSample();
    checkOutput("negNib2", sound, -26);
    repeat (2) waitSample();
    checkOutput("negEndDout", dout, 0);

    mem[12'h400] = 8'h70;
`ifdef JT6295_ATT_EN
    attExp = 15;
`else
    attExp = 30;
`endif
    applyStimulus(8'h81);
    applyStimulus(8'h12);
    waitSample();
    checkOutput("att2Nib1", sound, attExp);
    repeat (3) waitSample();
    checkOutput("att2EndDout", dout, 0);

    applyStimulus(8'h82);
    applyStimulus(8'h10);
    for (int i = 0; i < 7; i++) begin
      waitSample();
      checkOutput($sformatf("longNib%0d", i + 1), sound, longExp[i]);
    end

    hit3 = 1'b0;
    applyStimulus(8'h83);
    applyStimulus(8'h10);
    waitSample();
    checkOutput("restartSound", sound, 2047);
    checkOutput("restartNoTable", hit3, 0);
    checkOutput("restartBusy", dout, 1);

    applyStimulus(8'h08);
    checkOutput("stopDout", dout, 0);
    waitSample();
    checkOutput("stopSound", sound, 0);

    applyStimulus(8'h82);
    applyStimulus(8'h10);
    repeat (2) waitSample();
    applyStimulus(8'h08);
    applyStimulus(8'h82);
    applyStimulus(8'h10);
    waitSample();
    checkOutput("stopStartSound", sound, 30);
    checkOutput("stopStartBusy", dout, 1);
    applyStimulus(8'h08);

    hit0 = 1'b0;
    applyStimulus(8'h80);
    applyStimulus(8'h10);
    repeat (2) waitSample();
    checkOutput("phrase0NoTable", hit0, 0);
    checkOutput("phrase0Dout", dout, 0);

    ss = 1'b0;
    repeat (2) waitSample();
    t0 = lastSampleCyc;
    waitSample();
    checkOutput("period165", lastSampleCyc - t0, 660);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
